// File: rtl/ahb_mem_resp.sv
// AHB-Lite memory slave: 2^ADDR_W x 32-bit array with byte lanes, optional wait
// states and a two-cycle ERROR response for misaligned or oversized transfers.
module ahb_mem_resp #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY_IN,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      3'b000:  be = 4'b0001 << a;
      3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  logic [31:0]       mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_wr_q, pend_wr_d;
  logic [ADDR_W-1:0] pend_idx_q, pend_idx_d;
  logic [3:0]        pend_be_q, pend_be_d;
  logic              hreadyout_q, hreadyout_d;
  logic [1:0]        hresp_q, hresp_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic              accept;
  logic              legal;
  logic              wr_fire;
  logic [ADDR_W-1:0] new_idx;
  logic [31:0]       fwd_word;
  logic              unused_bits;

  assign unused_bits = ^{HADDR[31:ADDR_W+2], HTRANS[0]};

  // Address phase is only sampled while our own data phase is not stalling.
  assign accept  = HSEL && HREADY_IN && HTRANS[1] && hreadyout_q;
  assign legal   = (HSIZE == 3'b000) ||
                   (HSIZE == 3'b001 && !HADDR[0]) ||
                   (HSIZE == 3'b010 && HADDR[1:0] == 2'b00);
  assign new_idx = HADDR[ADDR_W+1:2];
  assign wr_fire = pend_v_q && pend_wr_q && hreadyout_q;

  // Read word with bypass of a write completing on the same edge.
  always_comb begin
    fwd_word = mem_q[new_idx];
    for (int i = 0; i < 4; i++) begin
      if (wr_fire && pend_idx_q == new_idx && pend_be_q[i])
        fwd_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_v_d   = pend_v_q;
    pend_wr_d  = pend_wr_q;
    pend_idx_d = pend_idx_q;
    pend_be_d  = pend_be_q;
    hrdata_d   = 32'h0;

    if (hreadyout_q && pend_v_q)
      pend_v_d = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!pend_wr_q)
            hrdata_d = mem_q[pend_idx_q];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (!legal) begin
            state_d = ST_ERR1;
          end else begin
            pend_v_d   = 1'b1;
            pend_wr_d  = HWRITE;
            pend_idx_d = new_idx;
            pend_be_d  = lane_en(HSIZE, HADDR[1:0]);
            if (WAIT_STATES == 0) begin
              if (!HWRITE)
                hrdata_d = fwd_word;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = CNT_W'(WAIT_STATES);
            end
          end
        end
      end
    endcase

    hreadyout_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
    hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_idx_q  <= '0;
      pend_be_q   <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
      hrdata_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_v_q    <= pend_v_d;
      pend_wr_q   <= pend_wr_d;
      pend_idx_q  <= pend_idx_d;
      pend_be_q   <= pend_be_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Array is never reset; writes commit on the completing edge of the data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESET && wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (pend_be_q[i])
          mem_q[pend_idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_mem_resp.sv
// Directed bench for ahb_mem_resp: one zero-wait and one 3-wait-state instance
// share the bus; use0 steers HSEL to one of them.
module tb_ahb_mem_resp;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel, use0;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HADDR, HWDATA;

  logic        sel0, sel3, rdy0, rdy3;
  logic [1:0]  resp0, resp3;
  logic [31:0] rdata0, rdata3;

  int checks = 0;
  int errors = 0;

  assign sel0 = hsel && use0;
  assign sel3 = hsel && !use0;

  always #5 HCLK = ~HCLK;

  ahb_mem_resp #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HREADY_IN(rdy0),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_mem_resp #(.ADDR_W(10), .WAIT_STATES(3)) u_dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel3), .HREADY_IN(rdy3),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr(input logic sel, input logic [1:0] tr, input logic [2:0] sz,
                      input logic wr, input logic [31:0] a);
    hsel   = sel;
    HTRANS = tr;
    HSIZE  = sz;
    HWRITE = wr;
    HADDR  = a;
  endtask

  task automatic idle();
    addr(1'b0, 2'b00, 3'b010, 1'b0, 32'h0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks ready/resp/rdata of the selected instance together.
  task automatic chk_bus(input string tag, input logic r, input logic [1:0] rs,
                         input logic [31:0] d);
    if (use0) begin
      chk({tag, ".rdy"},  32'(rdy0),  32'(r));
      chk({tag, ".resp"}, 32'(resp0), 32'(rs));
      chk({tag, ".data"}, rdata0,     d);
    end else begin
      chk({tag, ".rdy"},  32'(rdy3),  32'(r));
      chk({tag, ".resp"}, 32'(resp3), 32'(rs));
      chk({tag, ".data"}, rdata3,     d);
    end
  endtask

  initial begin
    HRESET = 1'b1;
    use0   = 1'b1;
    HWDATA = 32'h0;
    idle();
    tick();
    tick();
    chk_bus("reset0", 1'b1, 2'b00, 32'h0);
    use0 = 1'b0;
    chk_bus("reset3", 1'b1, 2'b00, 32'h0);
    use0 = 1'b1;
    HRESET = 1'b0;

    // Word write then back-to-back read on an aliased high address
    addr(1'b1, 2'b10, 3'b010, 1'b1, 32'h4001_0000);
    tick();
    HWDATA = 32'hDEAD_BEEF;
    addr(1'b1, 2'b10, 3'b010, 1'b0, 32'h4001_0000);
    chk_bus("wr_dp", 1'b1, 2'b00, 32'h0);
    tick();
    chk_bus("rd_fwd", 1'b1, 2'b00, 32'hDEAD_BEEF);
    idle();
    tick();
    chk_bus("rd_after", 1'b1, 2'b00, 32'h0);

    // Byte and halfword lane writes
    addr(1'b1, 2'b10, 3'b010, 1'b1, 32'h10);
    tick();
    HWDATA = 32'h0;
    addr(1'b1, 2'b11, 3'b000, 1'b1, 32'h11);
    tick();
    HWDATA = 32'hAAAA_AAAA;
    addr(1'b1, 2'b11, 3'b001, 1'b1, 32'h12);
    tick();
    HWDATA = 32'h5566_5566;
    addr(1'b1, 2'b10, 3'b010, 1'b0, 32'h10);
    tick();
    chk_bus("lanes", 1'b1, 2'b00, 32'h5566_AA00);
    idle();
    tick();

    // Misaligned word write
    addr(1'b1, 2'b10, 3'b010, 1'b1, 32'h02);
    tick();
    HWDATA = 32'hFFFF_FFFF;
    idle();
    chk_bus("err1_mis", 1'b0, 2'b01, 32'h0);
    tick();
    chk_bus("err2_mis", 1'b1, 2'b01, 32'h0);
    tick();
    chk_bus("err_done", 1'b1, 2'b00, 32'h0);
    // Oversized transfer
    addr(1'b1, 2'b10, 3'b011, 1'b1, 32'h00);
    tick();
    idle();
    chk_bus("err1_size", 1'b0, 2'b01, 32'h0);
    tick();
    chk_bus("err2_size", 1'b1, 2'b01, 32'h0);
    addr(1'b1, 2'b10, 3'b010, 1'b0, 32'h00);
    tick();
    idle();
    chk_bus("rd_after_err", 1'b1, 2'b00, 32'hDEAD_BEEF);
    tick();

    // BUSY with select, NONSEQ without select
    addr(1'b1, 2'b01, 3'b010, 1'b1, 32'h10);
    tick();
    HWDATA = 32'hFFFF_FFFF;
    addr(1'b0, 2'b10, 3'b010, 1'b1, 32'h10);
    chk_bus("busy", 1'b1, 2'b00, 32'h0);
    tick();
    idle();
    chk_bus("desel", 1'b1, 2'b00, 32'h0);
    tick();
    addr(1'b1, 2'b10, 3'b010, 1'b0, 32'h10);
    tick();
    idle();
    chk_bus("unchanged", 1'b1, 2'b00, 32'h5566_AA00);
    tick();

    // Wait-state instance: write then read, each 3 stall cycles
    use0 = 1'b0;
    addr(1'b1, 2'b10, 3'b010, 1'b1, 32'h20);
    tick();
    HWDATA = 32'hCAFE_F00D;
    idle();
    for (int i = 0; i < 3; i++) begin
      chk_bus($sformatf("ws_wr%0d", i), 1'b0, 2'b00, 32'h0);
      tick();
    end
    chk_bus("ws_wr_done", 1'b1, 2'b00, 32'h0);
    addr(1'b1, 2'b10, 3'b010, 1'b0, 32'h20);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk_bus($sformatf("ws_rd%0d", i), 1'b0, 2'b00, 32'h0);
      tick();
    end
    chk_bus("ws_rd_done", 1'b1, 2'b00, 32'hCAFE_F00D);
    tick();

    // Reset in the second wait cycle discards the write
    addr(1'b1, 2'b10, 3'b010, 1'b1, 32'h20);
    tick();
    HWDATA = 32'h1234_5678;
    idle();
    tick();
    chk_bus("rst_pre", 1'b0, 2'b00, 32'h0);
    HRESET = 1'b1;
    #1;
    chk_bus("rst_async", 1'b1, 2'b00, 32'h0);
    tick();
    HRESET = 1'b0;
    addr(1'b1, 2'b10, 3'b010, 1'b0, 32'h20);
    tick();
    idle();
    chk_bus("rst_first_acc", 1'b0, 2'b00, 32'h0);
    tick();
    tick();
    tick();
    chk_bus("rst_rd", 1'b1, 2'b00, 32'hCAFE_F00D);
    tick();

    // Zero-wait instance kept its array across reset
    use0 = 1'b1;
    addr(1'b1, 2'b10, 3'b010, 1'b0, 32'h10);
    tick();
    idle();
    chk_bus("mem_kept", 1'b1, 2'b00, 32'h5566_AA00);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_mem_resp.md
AHB_MEM_RESP -- requirements
Module: ahb_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width; the array holds 2^ADDR_W 32-bit words (4 KB at default).
REQ-002 SHALL have parameter WAIT_STATES, default 0, range 0-15, meaning HREADYOUT-low cycles inserted before completing each OKAY transfer.
REQ-003 SHALL have port HCLK  in  1  bus clock; all logic rises on its rising edge.
REQ-004 SHALL have port HRESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port HSEL  in  1  slave select from the address decoder.
REQ-006 SHALL have port HREADY_IN  in  1  bus-wide ready; an address phase is valid only when it is 1.
REQ-007 SHALL have port HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 SHALL have port HSIZE  in  3  transfer size: 000 byte, 001 halfword, 010 word.
REQ-009 SHALL have port HWRITE  in  1  1 = write, 0 = read.
REQ-010 SHALL have port HADDR  in  32  byte address; only HADDR[ADDR_W+1:0] is decoded.
REQ-011 SHALL have port HWDATA  in  32  write data, valid in the data phase.
REQ-012 SHALL have port HREADYOUT  out  1  data-phase complete.
REQ-013 SHALL have port HRESP  out  2  response: 00 OKAY, 01 ERROR.
REQ-014 SHALL have port HRDATA  out  32  read data.

Function
REQ-015 Address phase accepted: cycle with HSEL=1, HREADY_IN=1 and HTRANS[1]=1; HADDR, HSIZE and HWRITE are latched at that edge.
REQ-016 IDLE/BUSY address phases, or HSEL=0, SHALL produce no transfer; the next data phase is zero-wait OKAY.
REQ-017 FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE -> WAIT on an accepted legal transfer when WAIT_STATES>0.
- IDLE -> ERR1 on an accepted illegal transfer.
- WAIT: holds for exactly WAIT_STATES cycles with HREADYOUT=0, HRESP=OKAY; then one cycle HREADYOUT=1 and returns to IDLE.
- ERR1: one cycle, HREADYOUT=0, HRESP=ERROR -> ERR2.
- ERR2: one cycle, HREADYOUT=1, HRESP=ERROR -> IDLE.
REQ-018 WAIT_STATES=0: a legal transfer completes in the first data-phase cycle (HREADYOUT=1, OKAY).
REQ-019 Illegal transfer: HSIZE>010; halfword with HADDR[0]=1; word with HADDR[1:0]!=00. The array SHALL NOT be modified.
REQ-020 Byte lanes are little-endian.
- Byte: lane HADDR[1:0].
- Halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
- Word: all four lanes.
REQ-021 A write SHALL update only enabled lanes, using HWDATA sampled on the completing (HREADYOUT=1) cycle.
REQ-022 A read SHALL present the full addressed 32-bit word on HRDATA in the completing cycle. At all other times HRDATA SHALL be 0.
REQ-023 A read SHALL return the effect of every previously completed write, including a write completing in the immediately preceding cycle to the same word (no stale data).
REQ-024 Pipelining: a new address phase SHALL be accepted in the completing cycle of the previous data phase, giving back-to-back zero-wait throughput of one transfer per cycle.
REQ-025 While HREADYOUT=0, the address-phase inputs SHALL be ignored.
REQ-026 Address bits above ADDR_W+1 SHALL be ignored (aliasing permitted).

Reset
REQ-027 While HRESET=1, the block SHALL hold HREADYOUT=1, HRESP=00, HRDATA=0 and FSM=IDLE, with the latched address phase cleared.
REQ-028 Array contents SHALL NOT be reset.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer, and any pending write SHALL be discarded.
REQ-030 The first address phase SHALL be accepted on the first rising edge after HRESET falls.

Verification
REQ-031 Word write then read, WAIT_STATES=0:
- Stimulus: write 0x4001_0000 <= 0xDEAD_BEEF, then read the same address back-to-back.
- Response: read data phase HRDATA=0xDEAD_BEEF, HREADYOUT=1, OKAY, no stall.
REQ-032 Byte and halfword writes:
- Stimulus: word 0x0000_0000 at 0x10; byte write 0xAA to 0x11; halfword write 0x5566 to 0x12; word read 0x10.
- Response: HRDATA=0x5566_AA00.
REQ-033 Wait states, WAIT_STATES=3:
- Stimulus: read.
- Response: HREADYOUT low for 3 cycles, then high with data; throughput one transfer per 4 cycles.
REQ-034 Illegal transfers:
- Stimulus: word write to 0x02 with HWDATA=0xFFFF_FFFF; also HSIZE=011.
- Response: ERR1 then ERR2 (HREADYOUT 0 then 1, HRESP=01 both cycles); subsequent read of 0x00 returns the unchanged value.
REQ-035 Reset mid-wait:
- Stimulus: WAIT_STATES=3, write 0x1234_5678 to 0x20, assert HRESET in the second wait cycle.
- Response: outputs return to reset values immediately; a later read of 0x20 returns the pre-write value.
REQ-036 IDLE/BUSY and deselect:
- Stimulus: HTRANS=01 with HSEL=1; HTRANS=10 with HSEL=0.
- Response: HREADYOUT=1, HRESP=00, HRDATA=0, array unchanged.
